// File: rtl/branch_pred_btb_if.sv
// Fetch-lookup and execute-update signals of the branch target buffer.
// The master drives PCs and resolved outcomes; the slave returns the prediction.
interface branch_pred_btb_if #(
   parameter int unsigned ADDR_WIDTH = 64
);
   logic                  i_stall_mem;
   logic [ADDR_WIDTH-1:0] i_pc;
   logic                  i_branch_exec;
   logic                  i_branch_taken_exec;
   logic [1:0]            i_btb_way_exec;
   logic [ADDR_WIDTH-1:0] i_pc_exec;
   logic [ADDR_WIDTH-1:0] i_pc_target_exec;
   logic                  o_branch_pred_taken;
   logic [ADDR_WIDTH-1:0] o_pc_target_pred;
   logic [1:0]            o_btb_way;
   logic                  o_btb_hit;

   modport master (
      output i_stall_mem, i_pc, i_branch_exec, i_branch_taken_exec,
             i_btb_way_exec, i_pc_exec, i_pc_target_exec,
      input  o_branch_pred_taken, o_pc_target_pred, o_btb_way, o_btb_hit
   );

   modport slave (
      input  i_stall_mem, i_pc, i_branch_exec, i_branch_taken_exec,
             i_btb_way_exec, i_pc_exec, i_pc_target_exec,
      output o_branch_pred_taken, o_pc_target_pred, o_btb_way, o_btb_hit
   );
endinterface

// File: rtl/branch_pred_btb.sv
// 4-way set-associative BTB with 2-bit direction counters and tree pseudo-LRU.
// Lookup is combinational from the fetch PC; resolved branches update on the clock edge.
module branch_pred_btb #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned SET_COUNT  = 16
) (
   input  logic             i_clk,
   input  logic             i_arst,
   branch_pred_btb_if.slave btb
);
   localparam int unsigned SET_W = $clog2(SET_COUNT);
   localparam int unsigned TAG_W = ADDR_WIDTH - SET_W - 2;
   localparam int unsigned WAYS  = 4;

   logic                  valid_q [SET_COUNT][WAYS];
   logic [1:0]            cnt_q   [SET_COUNT][WAYS];
   logic [TAG_W-1:0]      tag_q   [SET_COUNT][WAYS];
   logic [ADDR_WIDTH-1:0] tgt_q   [SET_COUNT][WAYS];
   logic [2:0]            plru_q  [SET_COUNT];

   logic [SET_W-1:0] lk_set, up_set;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, lk_inv_found;
   logic [1:0]       lk_hit_way, lk_inv_way, lk_victim;
   logic             upd, up_match, up_alloc, up_touch;
   logic [1:0]       up_way;
   logic             unused_pc_lsbs;

   assign lk_set = btb.i_pc[SET_W+1:2];
   assign lk_tag = btb.i_pc[ADDR_WIDTH-1:SET_W+2];
   assign up_set = btb.i_pc_exec[SET_W+1:2];
   assign up_tag = btb.i_pc_exec[ADDR_WIDTH-1:SET_W+2];
   assign up_way = btb.i_btb_way_exec;
   assign unused_pc_lsbs = ^{btb.i_pc[1:0], btb.i_pc_exec[1:0]};

   always_comb begin
      lk_hit       = 1'b0;
      lk_hit_way   = '0;
      lk_inv_found = 1'b0;
      lk_inv_way   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag) && !lk_hit) begin
            lk_hit     = 1'b1;
            lk_hit_way = 2'(w);
         end
         if (!valid_q[lk_set][w] && !lk_inv_found) begin
            lk_inv_found = 1'b1;
            lk_inv_way   = 2'(w);
         end
      end
   end

   assign lk_victim = plru_q[lk_set][0] ? {1'b1, plru_q[lk_set][2]}
                                        : {1'b0, plru_q[lk_set][1]};

   always_comb begin
      btb.o_btb_hit           = lk_hit;
      btb.o_branch_pred_taken = lk_hit & cnt_q[lk_set][lk_hit_way][1];
      btb.o_pc_target_pred    = lk_hit ? tgt_q[lk_set][lk_hit_way] : '0;
      btb.o_btb_way           = lk_hit ? lk_hit_way : (lk_inv_found ? lk_inv_way : lk_victim);
   end

   assign upd      = btb.i_branch_exec & ~btb.i_stall_mem;
   assign up_match = valid_q[up_set][up_way] && (tag_q[up_set][up_way] == up_tag);
   assign up_alloc = upd && !up_match && btb.i_branch_taken_exec;
   assign up_touch = upd && (up_match || btb.i_branch_taken_exec);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int unsigned s = 0; s < SET_COUNT; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               cnt_q[s][w]   <= 2'b01;
            end
            plru_q[s] <= '0;
         end
      end else begin
         if (upd && up_match) begin
            if (btb.i_branch_taken_exec) begin
               if (cnt_q[up_set][up_way] != 2'b11)
                  cnt_q[up_set][up_way] <= cnt_q[up_set][up_way] + 2'd1;
            end else if (cnt_q[up_set][up_way] != 2'b00) begin
               cnt_q[up_set][up_way] <= cnt_q[up_set][up_way] - 2'd1;
            end
         end
         if (up_alloc) begin
            valid_q[up_set][up_way] <= 1'b1;
            cnt_q[up_set][up_way]   <= 2'b10;
         end
         // Point the tree away from the way just used.
         if (up_touch) begin
            plru_q[up_set][0] <= ~up_way[1];
            if (!up_way[1]) plru_q[up_set][1] <= ~up_way[0];
            else            plru_q[up_set][2] <= ~up_way[0];
         end
      end
   end

   // Tag/target storage carries no reset; valid bits gate every use of it.
   always_ff @(posedge i_clk) begin
      if (upd && btb.i_branch_taken_exec)
         tgt_q[up_set][up_way] <= btb.i_pc_target_exec;
      if (up_alloc)
         tag_q[up_set][up_way] <= up_tag;
   end
endmodule

// File: tb/tb_branch_pred_btb.sv
// Bench for branch_pred_btb: directed vector table, reset corner sequence,
// then randomized traffic checked against a set/way table model.
module tb_branch_pred_btb;
   localparam int unsigned AW   = 64;
   localparam int unsigned SETS = 16;
   localparam int unsigned SW   = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_pred_btb_if #(.ADDR_WIDTH(AW)) bus ();
   branch_pred_btb #(.ADDR_WIDTH(AW), .SET_COUNT(SETS)) dut (
      .i_clk (clk),
      .i_arst(rst),
      .btb   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] pc, input bit br, input bit tk, input bit [1:0] way,
                        input logic [63:0] pcx, input logic [63:0] tgt, input bit stall);
      bus.i_pc                = pc;
      bus.i_branch_exec       = br;
      bus.i_branch_taken_exec = tk;
      bus.i_btb_way_exec      = way;
      bus.i_pc_exec           = pcx;
      bus.i_pc_target_exec    = tgt;
      bus.i_stall_mem         = stall;
   endtask

   task automatic check_out(input string tag, input bit hit, input bit tk,
                            input logic [63:0] tgt, input bit [1:0] way);
      check({tag, "_hit"},    64'(bus.o_btb_hit), 64'(hit));
      check({tag, "_taken"},  64'(bus.o_branch_pred_taken), 64'(tk));
      check({tag, "_target"}, bus.o_pc_target_pred, tgt);
      check({tag, "_way"},    64'(bus.o_btb_way), 64'(way));
   endtask

   typedef struct {
      logic [63:0] pc;
      bit          br, tk;
      bit [1:0]    way;
      logic [63:0] pcx, tgt;
      bit          stall;
      bit          e_hit, e_tk;
      logic [63:0] e_tgt;
      bit [1:0]    e_way;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [63:0] pc, bit br, bit tk, bit [1:0] way, logic [63:0] pcx,
                               logic [63:0] tgt, bit stall, bit e_hit, bit e_tk,
                               logic [63:0] e_tgt, bit [1:0] e_way);
      vec_t v;
      v.pc = pc; v.br = br; v.tk = tk; v.way = way; v.pcx = pcx; v.tgt = tgt; v.stall = stall;
      v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_way = e_way;
      return v;
   endfunction

   // Reference model: plain per-set entry tables following the update rules.
   bit          mv   [SETS][4];
   logic [63:0] mtag [SETS][4];
   logic [63:0] mtgt [SETS][4];
   int          mcnt [SETS][4];
   bit          mb0 [SETS], mb1 [SETS], mb2 [SETS];

   function automatic int m_set(logic [63:0] pc);
      return int'((pc >> 2) % SETS);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < 4; w++) begin
            mv[s][w] = 0;
            mcnt[s][w] = 1;
         end
         mb0[s] = 0; mb1[s] = 0; mb2[s] = 0;
      end
   endtask

   task automatic model_lookup(input logic [63:0] pc, output bit hit, output bit tk,
                               output logic [63:0] tgt, output bit [1:0] way);
      int s;
      int found;
      s = m_set(pc);
      found = -1;
      hit = 0; tk = 0; tgt = '0;
      for (int w = 0; w < 4; w++)
         if (found < 0 && mv[s][w] && mtag[s][w] == (pc >> (SW + 2))) found = w;
      if (found >= 0) begin
         hit = 1;
         tk  = (mcnt[s][found] >= 2);
         tgt = mtgt[s][found];
         way = 2'(found);
      end else begin
         for (int w = 3; w >= 0; w--)
            if (!mv[s][w]) found = w;
         if (found >= 0) way = 2'(found);
         else            way = mb0[s] ? 2'(2 + int'(mb2[s])) : 2'(int'(mb1[s]));
      end
   endtask

   task automatic model_update(input bit br, input bit tk, input bit [1:0] way,
                               input logic [63:0] pcx, input logic [63:0] tgt, input bit stall);
      int s;
      int w;
      bit used;
      if (!br || stall) return;
      s = m_set(pcx);
      w = int'(way);
      used = 0;
      if (mv[s][w] && mtag[s][w] == (pcx >> (SW + 2))) begin
         used = 1;
         if (tk) begin
            mcnt[s][w] = (mcnt[s][w] < 3) ? mcnt[s][w] + 1 : 3;
            mtgt[s][w] = tgt;
         end else begin
            mcnt[s][w] = (mcnt[s][w] > 0) ? mcnt[s][w] - 1 : 0;
         end
      end else if (tk) begin
         used = 1;
         mv[s][w] = 1;
         mtag[s][w] = pcx >> (SW + 2);
         mtgt[s][w] = tgt;
         mcnt[s][w] = 2;
      end
      if (used) begin
         mb0[s] = (w < 2);
         if (w < 2) mb1[s] = (w == 0);
         else       mb2[s] = (w == 2);
      end
   endtask

   function automatic logic [63:0] rand_pc();
      logic [63:0] hi;
      case ($urandom_range(0, 5))
         0: hi = 64'h0;
         1: hi = 64'h1;
         2: hi = 64'h2;
         3: hi = 64'hDEAD;
         4: hi = 64'h0FFF_FFFF_FFFF_FFFF;
         default: hi = 64'h3;
      endcase
      return (hi << (SW + 2)) | (64'($urandom_range(0, 3)) << 2) | 64'($urandom_range(0, 3));
   endfunction

   initial begin
      bit          r_hit, r_tk;
      logic [63:0] r_tgt, pc, pcx, tgt;
      bit [1:0]    r_way, way;
      bit          br, tk, stall;

      // Directed table: expected values are the pre-update lookup of that cycle.
      //                 pc       br tk way pcx      tgt       st hit tk target    way
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 64'h0,    0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0, 0, 0, 64'h0,    0));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 0, 0, 64'h1000, 64'h1004, 0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 0, 0, 64'h1000, 64'h1004, 0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 0, 0, 64'h1000, 64'h1004, 0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 0, 0, 64'h1000, 64'h1004, 0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h3000, 1, 0, 0, 64'h3000, 64'h3004, 0, 0, 0, 64'h0,    1));
      vecs.push_back(mk(64'h3000, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 64'h0,    1));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 1, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 1, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 1, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 1, 0, 0, 64'h1000, 64'h1004, 0, 1, 1, 64'h2000, 0));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 1, 0, 64'h2000, 0));
      vecs.push_back(mk(64'h1040, 1, 1, 1, 64'h1040, 64'h2040, 0, 0, 0, 64'h0,    1));
      vecs.push_back(mk(64'h1080, 1, 1, 2, 64'h1080, 64'h2080, 0, 0, 0, 64'h0,    2));
      vecs.push_back(mk(64'h10C0, 1, 1, 3, 64'h10C0, 64'h20C0, 0, 0, 0, 64'h0,    3));
      vecs.push_back(mk(64'h1100, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 64'h0,    0));
      vecs.push_back(mk(64'h1040, 0, 0, 0, 64'h0,    64'h0,    0, 1, 1, 64'h2040, 1));
      vecs.push_back(mk(64'h10C0, 1, 1, 0, 64'h1100, 64'h3100, 0, 1, 1, 64'h20C0, 3));
      vecs.push_back(mk(64'h1000, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 64'h0,    2));
      vecs.push_back(mk(64'h1100, 0, 0, 0, 64'h0,    64'h0,    0, 1, 1, 64'h3100, 0));

      rst = 1'b1;
      drive(64'h1000, 0, 0, 0, 64'h0, 64'h0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 0, 0, 64'h0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].pc, vecs[i].br, vecs[i].tk, vecs[i].way, vecs[i].pcx, vecs[i].tgt, vecs[i].stall);
         #1;
         check_out($sformatf("v%0d", i), vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt, vecs[i].e_way);
         @(posedge clk);
         #1;
      end

      // Reset asserted mid-cycle while an update is pending, then released with the update still held.
      drive(64'h1000, 1, 1, 0, 64'h1000, 64'h2000, 0);
      #1;
      rst = 1'b1;
      #1;
      check_out("rst_mid", 0, 0, 64'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_out("rst_rel", 0, 0, 64'h0, 0);
      @(posedge clk);
      #1;
      drive(64'h1000, 0, 0, 0, 64'h0, 64'h0, 0);
      #1;
      check_out("post_rel", 1, 1, 64'h2000, 0);
      drive(64'h1040, 0, 0, 0, 64'h0, 64'h0, 0);
      #1;
      check_out("post_rel_miss", 0, 0, 64'h0, 1);
      @(posedge clk);
      #1;

      // Randomized traffic against the model.
      rst = 1'b1;
      model_reset();
      drive(64'h0, 0, 0, 0, 64'h0, 64'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         pc    = rand_pc();
         pcx   = rand_pc();
         tgt   = {$urandom, $urandom};
         br    = ($urandom_range(0, 9) < 6);
         tk    = $urandom_range(0, 1) == 1;
         stall = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 4) == 0) way = 2'($urandom_range(0, 3));
         else model_lookup(pcx, r_hit, r_tk, r_tgt, way);
         drive(pc, br, tk, way, pcx, tgt, stall);
         #1;
         model_lookup(pc, r_hit, r_tk, r_tgt, r_way);
         check_out($sformatf("rnd%0d", n), r_hit, r_tk, r_tgt, r_way);
         model_update(br, tk, way, pcx, tgt, stall);
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
